// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the host-command framer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_OPC,
    ST_LEN,
    ST_ARG,
    ST_CHK,
    ST_ISSUE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_CHAR = 8'h24;
  localparam logic [7:0] OPC_START = 8'h53;
  localparam logic [7:0] OPC_STOP  = 8'h50;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Receive-FIFO head interface: the FIFO presents a byte, the parser pops it.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_present;
  logic       rx_read;

  modport master (output rx_data, output rx_present, input rx_read);
  modport slave  (input rx_data, input rx_present, output rx_read);
endinterface

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte watchdog: reloads to TIMEOUT_CYC on clear, counts down, flags zero.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (clear)        cnt <= W'(TIMEOUT_CYC);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC,OPC,LEN,ARG[],CHK from the RX FIFO into command strobes and error reports.
//  state    | meaning
//  HUNT     | discard bytes until SYNC_CHAR
//  OPC      | take opcode, seed checksum
//  LEN      | take argument count, reject if too long
//  ARG      | collect LEN argument bytes
//  CHK      | compare checksum byte
//  ISSUE    | good frame strobes visible, no pop
module uart_cmd_parser #(
  parameter int unsigned ARG_MAX     = 9,
  parameter int unsigned NUM_PULSE   = 8,
  parameter logic [7:0]  OPC_BASE    = 8'h31,
  parameter logic [7:0]  SYNC_CHAR   = uart_cmd_pkg::SYNC_CHAR,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_cmd_parser_if.slave       rx,
  output logic [NUM_PULSE-1:0]   pulse_out,
  output logic                   run_level,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_opcode,
  output logic [4:0]             cmd_len,
  output logic [8*ARG_MAX-1:0]   cmd_args,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [7:0]             err_count
);
  import uart_cmd_pkg::*;

  state_t               state, state_nxt;
  logic                 rd_q, pop;
  logic [7:0]           byte_in;
  logic [7:0]           opc_q, chk_q;
  logic [4:0]           len_q;
  logic [3:0]           idx_q;
  logic [8*ARG_MAX-1:0] args_q;
  logic                 expired, tmo_clear;
  logic                 go_issue, err_set;
  logic [1:0]           err_nxt;
  logic [7:0]           pulse_idx;
  logic                 pulse_hit;

  // FIFO empty flag lags a pop by one cycle, so never pop twice in a row.
  assign pop        = rx.rx_present && !rd_q && (state != ST_ISSUE) && !reset;
  assign rx.rx_read = pop;
  assign byte_in    = rx.rx_data;
  assign tmo_clear  = pop || (state == ST_HUNT);

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    go_issue  = 1'b0;
    err_set   = 1'b0;
    err_nxt   = ERR_NONE;
    if ((state == ST_OPC || state == ST_LEN || state == ST_ARG || state == ST_CHK)
        && expired && !pop) begin
      err_set   = 1'b1;
      err_nxt   = ERR_TIMEOUT;
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT:  if (pop && byte_in == SYNC_CHAR) state_nxt = ST_OPC;
        ST_OPC:   if (pop) state_nxt = ST_LEN;
        ST_LEN: begin
          if (pop) begin
            if (byte_in > 8'(ARG_MAX)) begin
              err_set   = 1'b1;
              err_nxt   = ERR_LEN;
              state_nxt = ST_HUNT;
            end else if (byte_in == 8'd0) begin
              state_nxt = ST_CHK;
            end else begin
              state_nxt = ST_ARG;
            end
          end
        end
        ST_ARG:   if (pop && ({1'b0, idx_q} == len_q - 5'd1)) state_nxt = ST_CHK;
        ST_CHK: begin
          if (pop) begin
            if (byte_in == chk_q) begin
              go_issue  = 1'b1;
              state_nxt = ST_ISSUE;
            end else begin
              err_set   = 1'b1;
              err_nxt   = ERR_CHK;
              state_nxt = ST_HUNT;
            end
          end
        end
        ST_ISSUE: state_nxt = ST_HUNT;
        default:  state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_HUNT;
      rd_q   <= 1'b0;
      opc_q  <= '0;
      chk_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      args_q <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= pop;
      case (state)
        ST_HUNT: args_q <= '0;
        ST_OPC: if (pop) begin
          opc_q <= byte_in;
          chk_q <= byte_in;
        end
        ST_LEN: if (pop) begin
          chk_q <= chk_q ^ byte_in;
          len_q <= byte_in[4:0];
          idx_q <= '0;
        end
        ST_ARG: if (pop) begin
          args_q[{idx_q, 3'b000} +: 8] <= byte_in;
          chk_q <= chk_q ^ byte_in;
          idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign pulse_idx = opc_q - OPC_BASE;
  assign pulse_hit = (opc_q >= OPC_BASE) && ({24'd0, pulse_idx} < NUM_PULSE);

  // Results register on the good CHK pop, so strobes appear one cycle after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_out  <= '0;
      run_level  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
      cmd_len    <= '0;
      cmd_args   <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_count  <= '0;
    end else begin
      cmd_valid <= go_issue;
      err_valid <= err_set;
      pulse_out <= '0;
      if (go_issue) begin
        cmd_opcode <= opc_q;
        cmd_len    <= len_q;
        cmd_args   <= args_q;
        if (pulse_hit)             pulse_out <= NUM_PULSE'(1) << pulse_idx;
        if (opc_q == OPC_START)    run_level <= 1'b1;
        else if (opc_q == OPC_STOP) run_level <= 1'b0;
      end
      if (err_set) begin
        err_code <= err_nxt;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule
